// File: rtl/prog_imem_if.sv
// Fetch and byte-serial program-load signals shared by prog_imem and its user.
// The memory is the slave; the CPU fetch stage and loader together form the master.
interface prog_imem_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              prog_en;
    logic              prog_byte_valid;
    logic [7:0]        prog_byte;
    logic              prog_ready;
    logic              prog_done;
    logic [ADDR_W:0]   prog_count;
    logic              busy;

    modport master (
        output fetch_req, fetch_addr, prog_en, prog_byte_valid, prog_byte,
        input  fetch_valid, fetch_instr, prog_ready, prog_done, prog_count, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, prog_en, prog_byte_valid, prog_byte,
        output fetch_valid, fetch_instr, prog_ready, prog_done, prog_count, busy
    );
endinterface

// File: rtl/prog_imem.sv
// Synchronous instruction memory with 1-cycle registered fetch, clear-to-NOP sweep after
// reset and a byte-serial load port (LSB first) for replacing the program at run time.
module prog_imem #(
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned DATA_W         = 16,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter string       INIT_FILE      = ""
) (
    input logic        clk,
    input logic        rst,
    prog_imem_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned Bytes = DATA_W / 8;
    localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;

    typedef enum logic [1:0] {StClear, StRun, StLoad} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                block_q, block_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_q [Depth];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        count_d   = count_q;
        block_d   = block_q;
        done_d    = 1'b0;
        valid_d   = 1'b0;
        instr_d   = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        // A full-exit blocks re-entry until prog_en has been seen low.
        if (!bus.prog_en) block_d = 1'b0;

        unique case (state_q)
            StClear: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(Depth - 1)) begin
                    ptr_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.prog_en && !block_q) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    idx_d   = '0;
                    count_d = '0;
                end else if (bus.fetch_req) begin
                    valid_d = 1'b1;
                    instr_d = mem_q[bus.fetch_addr];
                end
            end
            StLoad: begin
                if (!bus.prog_en) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = StRun;
                end else if (bus.prog_byte_valid) begin
                    asm_d[8*idx_q +: 8] = bus.prog_byte;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IdxW'(Bytes - 1)) begin
                        mem_we    = 1'b1;
                        mem_wdata = asm_d;
                        ptr_d     = ptr_q + 1'b1;
                        idx_d     = '0;
                        if (count_q != (ADDR_W + 1)'(Depth)) count_d = count_q + 1'b1;
                        if (ptr_q == ADDR_W'(Depth - 1)) begin
                            done_d  = 1'b1;
                            block_d = 1'b1;
                            state_d = StRun;
                        end
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? StClear : StRun;
            ptr_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            count_q <= count_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            block_q <= block_d;
        end
    end

    // Storage is not reset so words survive a reset when no clear sweep runs.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[ptr_q] <= mem_wdata;
    end

    assign bus.fetch_valid = valid_q;
    assign bus.fetch_instr = instr_q;
    assign bus.prog_ready  = (state_q == StLoad);
    assign bus.prog_done   = done_q;
    assign bus.prog_count  = count_q;
    assign bus.busy        = (state_q != StRun);
endmodule

// File: tb/tb_prog_imem.sv
// Directed bench for prog_imem: dut_a clears on reset, dut_b keeps contents; both get identical
// stimulus so the reset-during-load case can be compared across the two configurations.
module tb_prog_imem;
    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_req;
    logic [5:0] fetch_addr;
    logic       prog_en;
    logic       prog_byte_valid;
    logic [7:0] prog_byte;

    int n_checks = 0;
    int n_err    = 0;
    int cnt;

    prog_imem_if #(.ADDR_W(6), .DATA_W(16)) ifa ();
    prog_imem_if #(.ADDR_W(6), .DATA_W(16)) ifb ();

    assign ifa.fetch_req       = fetch_req;
    assign ifa.fetch_addr      = fetch_addr;
    assign ifa.prog_en         = prog_en;
    assign ifa.prog_byte_valid = prog_byte_valid;
    assign ifa.prog_byte       = prog_byte;
    assign ifb.fetch_req       = fetch_req;
    assign ifb.fetch_addr      = fetch_addr;
    assign ifb.prog_en         = prog_en;
    assign ifb.prog_byte_valid = prog_byte_valid;
    assign ifb.prog_byte       = prog_byte;

    prog_imem #(.ADDR_W(6), .DATA_W(16), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    prog_imem #(.ADDR_W(6), .DATA_W(16), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [5:0] addr, input logic [15:0] exp, input string tag);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        check({tag, "_valid"}, {31'd0, ifa.fetch_valid}, 32'd1);
        check({tag, "_instr"}, {16'd0, ifa.fetch_instr}, {16'd0, exp});
    endtask

    task automatic send(input logic [7:0] b);
        prog_byte_valid = 1'b1;
        prog_byte       = b;
        tick();
        prog_byte_valid = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        cnt = 0;
        while (ifa.busy && cnt < 200) begin
            cnt++;
            tick();
        end
        check(tag, cnt, 64);
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        prog_en = 1'b0; prog_byte_valid = 1'b0; prog_byte = '0;
        tick();
        tick();
        check("rst_busy_a", {31'd0, ifa.busy}, 32'd1);
        check("rst_busy_b", {31'd0, ifb.busy}, 32'd0);
        check("rst_valid", {31'd0, ifa.fetch_valid}, 32'd0);
        check("rst_ready", {31'd0, ifa.prog_ready}, 32'd0);
        check("rst_done", {31'd0, ifa.prog_done}, 32'd0);
        check("rst_count", {25'd0, ifa.prog_count}, 32'd0);
        rst = 1'b0;
        wait_clear("clear_cycles");

        for (int k = 0; k < 64; k++) fetch(6'(k), 16'h0000, "clear_word");
        tick();
        check("idle_valid", {31'd0, ifa.fetch_valid}, 32'd0);
        check("idle_instr", {16'd0, ifa.fetch_instr}, 32'd0);

        // Short load then abort.
        prog_en = 1'b1;
        tick();
        check("load_ready", {31'd0, ifa.prog_ready}, 32'd1);
        check("load_busy", {31'd0, ifa.busy}, 32'd1);
        check("load_count0", {25'd0, ifa.prog_count}, 32'd0);
        send(8'h3B); send(8'hFE); send(8'h38); send(8'h01); send(8'h2B); send(8'h00);
        check("load_count3", {25'd0, ifa.prog_count}, 32'd3);
        prog_en = 1'b0;
        tick();
        check("abort_done", {31'd0, ifa.prog_done}, 32'd1);
        check("abort_ready", {31'd0, ifa.prog_ready}, 32'd0);
        fetch(6'd0, 16'hFE3B, "short_w0");
        check("done_pulse", {31'd0, ifa.prog_done}, 32'd0);
        fetch(6'd1, 16'h0138, "short_w1");
        fetch(6'd2, 16'h002B, "short_w2");
        fetch(6'd3, 16'h0000, "short_w3");
        check("short_count", {25'd0, ifa.prog_count}, 32'd3);

        // Pipelined fetch, one request per cycle.
        fetch_req = 1'b1;
        fetch_addr = 6'd0;
        tick();
        check("pipe_v0", {31'd0, ifa.fetch_valid}, 32'd1);
        check("pipe_i0", {16'd0, ifa.fetch_instr}, 32'hFE3B);
        fetch_addr = 6'd1;
        tick();
        check("pipe_v1", {31'd0, ifa.fetch_valid}, 32'd1);
        check("pipe_i1", {16'd0, ifa.fetch_instr}, 32'h0138);
        fetch_addr = 6'd2;
        tick();
        check("pipe_v2", {31'd0, ifa.fetch_valid}, 32'd1);
        check("pipe_i2", {16'd0, ifa.fetch_instr}, 32'h002B);
        fetch_req = 1'b0;
        tick();
        check("pipe_end", {31'd0, ifa.fetch_valid}, 32'd0);

        // Full load with prog_en held high throughout.
        prog_en = 1'b1;
        tick();
        for (int i = 0; i < 128; i++) send(8'(i));
        check("full_done", {31'd0, ifa.prog_done}, 32'd1);
        check("full_count", {25'd0, ifa.prog_count}, 32'd64);
        check("full_ready", {31'd0, ifa.prog_ready}, 32'd0);
        fetch(6'd63, 16'h7F7E, "full_first_run");
        check("no_reentry_busy", {31'd0, ifa.busy}, 32'd0);
        for (int k = 0; k < 64; k++) begin
            w = {8'(2 * k + 1), 8'(2 * k)};
            fetch(6'(k), w, "full_word");
        end
        check("no_reentry_ready", {31'd0, ifa.prog_ready}, 32'd0);
        prog_en = 1'b0;
        tick();
        prog_en = 1'b1;
        tick();
        check("reentry_ready", {31'd0, ifa.prog_ready}, 32'd1);
        check("reentry_count", {25'd0, ifa.prog_count}, 32'd0);

        // Abort mid-word; the byte presented with prog_en low is dropped.
        send(8'hAA); send(8'hBB); send(8'hCC);
        prog_en = 1'b0;
        send(8'hDD);
        check("midabort_done", {31'd0, ifa.prog_done}, 32'd1);
        check("midabort_count", {25'd0, ifa.prog_count}, 32'd1);
        fetch(6'd0, 16'hBBAA, "midabort_w0");
        fetch(6'd1, 16'h0302, "midabort_w1");

        // Reset during a load after 5 bytes.
        prog_en = 1'b1;
        tick();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        rst = 1'b1;
        tick();
        check("rstload_ready_a", {31'd0, ifa.prog_ready}, 32'd0);
        check("rstload_busy_a", {31'd0, ifa.busy}, 32'd1);
        check("rstload_ready_b", {31'd0, ifb.prog_ready}, 32'd0);
        check("rstload_busy_b", {31'd0, ifb.busy}, 32'd0);
        rst = 1'b0;
        prog_en = 1'b0;
        wait_clear("reclear_cycles");
        for (int k = 0; k < 64; k++) begin
            fetch(6'(k), 16'h0000, "reclear_word");
            if (k == 0) check("keep_b_w0", {16'd0, ifb.fetch_instr}, 32'h2211);
            if (k == 1) check("keep_b_w1", {16'd0, ifb.fetch_instr}, 32'h4433);
            if (k == 2) check("keep_b_w2", {16'd0, ifb.fetch_instr}, 32'h0504);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
